// File: rtl/rr_arb_pkg.sv
// Shared types and widths for the round-robin bus arbiter.
package rr_arb_pkg;

    localparam int HOLD_W = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } state_e;

    // Index width for n requesters; a single requester pair still needs one bit.
    function automatic int idw(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_bus_arbiter_if.sv
// Request/grant bundle between requesters (master side) and the arbiter (slave side).
interface rr_bus_arbiter_if #(
    parameter int N   = 4,
    parameter int IDW = rr_arb_pkg::idw(N)
);
    logic [N-1:0]   req;
    logic [N-1:0]   grant;
    logic           grant_valid;
    logic [IDW-1:0] grant_id;

    modport master (output req, input grant, input grant_valid, input grant_id);
    modport slave  (input req, output grant, output grant_valid, output grant_id);
endinterface

// File: rtl/rr_pick.sv
// Combinational rotate-and-find-first: first set bit of req & mask searching from last+1, wrapping.
module rr_pick
    import rr_arb_pkg::*;
#(
    parameter int N   = 4,
    parameter int IDW = idw(N)
) (
    input  logic [N-1:0]   req,
    input  logic [N-1:0]   mask,
    input  logic [IDW-1:0] last,
    output logic           found,
    output logic [IDW-1:0] idx
);

    logic [N-1:0] elig;

    assign elig = req & mask;

    always_comb begin
        int pos;
        // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
        pos   = 0;
        found = 1'b0;
        idx   = '0;
        for (int k = 1; k <= N; k++) begin
            pos = (int'(last) + k) % N;
            if (!found && elig[pos]) begin
                found = 1'b1;
                idx   = IDW'(pos);
            end
        end
    end

endmodule

// File: rtl/rr_bus_arbiter.sv
// Round-robin bus arbiter with registered one-hot grant and optional maximum hold time.
module rr_bus_arbiter
    import rr_arb_pkg::*;
#(
    parameter int N        = 4,
    parameter int MAX_HOLD = 8,
    parameter int IDW      = idw(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    output logic [N-1:0]   grant,
    output logic           grant_valid,
    output logic [IDW-1:0] grant_id
);

    state_e            state;
    logic [IDW-1:0]    last;
    logic [HOLD_W-1:0] hold_cnt;

    logic [N-1:0]      owner_bit;
    logic [N-1:0]      mask;
    logic              owner_req;
    logic              others;
    logic              expired;
    logic              found;
    logic [IDW-1:0]    pick_idx;
    logic              take_pick;

    // The current owner is always `last`, since last loads on every grant.
    assign owner_bit = N'(1) << last;
    assign owner_req = |(req & owner_bit);
    assign others    = |(req & ~owner_bit);
    assign expired   = (MAX_HOLD != 0) && (hold_cnt == HOLD_W'(MAX_HOLD - 1));

    // Only a forced hand-off at hold expiry excludes the still-requesting owner.
    assign mask = (state == OWNED && owner_req && expired) ? ~owner_bit : '1;

    assign take_pick = found &&
                       ((state == IDLE) || !owner_req || (expired && others));

    rr_pick #(.N(N), .IDW(IDW)) u_pick (
        .req   (req),
        .mask  (mask),
        .last  (last),
        .found (found),
        .idx   (pick_idx)
    );

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state       <= IDLE;
            grant       <= '0;
            grant_valid <= 1'b0;
            grant_id    <= '0;
            hold_cnt    <= '0;
            last        <= IDW'(N - 1);
        end else if (take_pick) begin
            state       <= OWNED;
            grant       <= N'(1) << pick_idx;
            grant_valid <= 1'b1;
            grant_id    <= pick_idx;
            last        <= pick_idx;
            hold_cnt    <= '0;
        end else if (state == OWNED) begin
            if (!owner_req) begin
                state       <= IDLE;
                grant       <= '0;
                grant_valid <= 1'b0;
                grant_id    <= '0;
            end else if (expired) begin
                hold_cnt <= '0;
            end else if (hold_cnt != '1) begin
                hold_cnt <= hold_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rr_bus_arbiter.sv
// Randomised and directed bench for rr_bus_arbiter with MAX_HOLD=4 and MAX_HOLD=0 instances.
module tb_rr_bus_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    rr_bus_arbiter_if #(.N(4)) bus4 ();
    rr_bus_arbiter_if #(.N(4)) bus0 ();

    rr_bus_arbiter #(.N(4), .MAX_HOLD(4)) dut4 (
        .clk (clk), .rst (rst), .req (bus4.req),
        .grant (bus4.grant), .grant_valid (bus4.grant_valid), .grant_id (bus4.grant_id)
    );

    rr_bus_arbiter #(.N(4), .MAX_HOLD(0)) dut0 (
        .clk (clk), .rst (rst), .req (bus0.req),
        .grant (bus0.grant), .grant_valid (bus0.grant_valid), .grant_id (bus0.grant_id)
    );

    logic [3:0] dg [2];
    logic       dv [2];
    logic [1:0] di [2];
    assign dg[0] = bus4.grant;  assign dv[0] = bus4.grant_valid;  assign di[0] = bus4.grant_id;
    assign dg[1] = bus0.grant;  assign dv[1] = bus0.grant_valid;  assign di[1] = bus0.grant_id;

    // Reference model: owner index (-1 = none), last owner, cycles held since (re)grant.
    int mh      [2] = '{4, 0};
    int m_owner [2] = '{-1, -1};
    int m_last  [2] = '{3, 3};
    int m_held  [2] = '{0, 0};

    function automatic int rr_first(input logic [3:0] r, input int from, input int excl);
        for (int k = 1; k <= 4; k++) begin
            int p;
            p = (from + k) % 4;
            if (p != excl && r[p]) return p;
        end
        return -1;
    endfunction

    function automatic void model_step(input int d, input logic [3:0] r, input logic rs);
        int o;
        int p;
        if (rs) begin
            m_owner[d] = -1;
            m_last[d]  = 3;
            m_held[d]  = 0;
            return;
        end
        o = m_owner[d];
        if (o < 0 || !r[o]) begin
            p = rr_first(r, m_last[d], -1);
            m_owner[d] = p;
            if (p >= 0) begin
                m_last[d] = p;
                m_held[d] = 1;
            end
        end else if (mh[d] != 0 && m_held[d] >= mh[d]) begin
            p = rr_first(r, m_last[d], o);
            if (p >= 0) begin
                m_owner[d] = p;
                m_last[d]  = p;
            end
            m_held[d] = 1;
        end else begin
            m_held[d]++;
        end
    endfunction

    task automatic tick(input logic [3:0] r, input logic rs);
        logic [3:0] eg;
        logic [1:0] ei;
        bus4.req = r;
        bus0.req = r;
        rst      = rs;
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            model_step(d, r, rs);
            eg = (m_owner[d] >= 0) ? 4'(1 << m_owner[d]) : 4'b0000;
            ei = (m_owner[d] >= 0) ? 2'(m_owner[d]) : 2'd0;
            total += 6;
            if (dg[d] !== eg) begin
                bad++;
                $display("FAIL grant dut%0d t=%0t req=%b: got %b want %b", d, $time, r, dg[d], eg);
            end
            if (dv[d] !== (eg != 4'b0000)) begin
                bad++;
                $display("FAIL grant_valid dut%0d t=%0t: got %b want %b", d, $time, dv[d], (eg != 4'b0000));
            end
            if (di[d] !== ei) begin
                bad++;
                $display("FAIL grant_id dut%0d t=%0t: got %0d want %0d", d, $time, di[d], ei);
            end
            if (!$onehot0(dg[d])) begin
                bad++;
                $display("FAIL onehot dut%0d t=%0t: got %b want one-hot or zero", d, $time, dg[d]);
            end
            if (dv[d] ? (dg[d] !== 4'(1 << di[d])) : (di[d] !== 2'd0)) begin
                bad++;
                $display("FAIL id_match dut%0d t=%0t: got id %0d grant %b want consistent", d, $time, di[d], dg[d]);
            end
            if ((dg[d] & ~r) !== 4'b0000) begin
                bad++;
                $display("FAIL unrequested dut%0d t=%0t: got grant %b want subset of req %b", d, $time, dg[d], r);
            end
        end
    endtask

    task automatic test_reset;
        tick(4'b1010, 1'b1);
        tick(4'b1111, 1'b1);
        total += 3;
        if (bus4.grant !== 4'b0000) begin bad++; $display("FAIL reset_grant: got %b want 0000", bus4.grant); end
        if (bus4.grant_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", bus4.grant_valid); end
        if (bus0.grant_id !== 2'd0) begin bad++; $display("FAIL reset_id: got %0d want 0", bus0.grant_id); end
    endtask

    task automatic test_single_hold;
        tick(4'b0000, 1'b1);
        for (int k = 0; k < 10; k++) begin
            tick(4'b0001, 1'b0);
            total++;
            if (bus4.grant !== 4'b0001) begin
                bad++;
                $display("FAIL single_hold cycle %0d: got %b want 0001", k, bus4.grant);
            end
        end
    endtask

    task automatic test_rotation;
        logic [3:0] want;
        tick(4'b0000, 1'b1);
        for (int k = 0; k < 20; k++) begin
            tick(4'b1111, 1'b0);
            want = 4'(1 << ((k / 4) % 4));
            total++;
            if (bus4.grant !== want) begin
                bad++;
                $display("FAIL rotation cycle %0d: got %b want %b", k, bus4.grant, want);
            end
        end
    endtask

    task automatic test_no_limit;
        tick(4'b0000, 1'b1);
        tick(4'b0100, 1'b0);
        for (int k = 0; k < 10; k++) begin
            tick(4'b1111, 1'b0);
            total++;
            if (bus0.grant !== 4'b0100) begin
                bad++;
                $display("FAIL no_limit cycle %0d: got %b want 0100", k, bus0.grant);
            end
        end
        tick(4'b1011, 1'b0);
        total++;
        if (bus0.grant !== 4'b1000) begin
            bad++;
            $display("FAIL no_limit_handover: got %b want 1000", bus0.grant);
        end
    endtask

    task automatic test_drop_idle;
        tick(4'b0000, 1'b1);
        tick(4'b0010, 1'b0);
        tick(4'b0000, 1'b0);
        total += 2;
        if (bus4.grant !== 4'b0000) begin bad++; $display("FAIL drop_grant: got %b want 0000", bus4.grant); end
        if (bus4.grant_valid !== 1'b0) begin bad++; $display("FAIL drop_valid: got %b want 0", bus4.grant_valid); end
        tick(4'b1001, 1'b0);
        total++;
        if (bus4.grant !== 4'b1000) begin bad++; $display("FAIL drop_rearb: got %b want 1000", bus4.grant); end
    endtask

    task automatic test_mid_reset;
        tick(4'b0000, 1'b1);
        tick(4'b0100, 1'b0);
        tick(4'b1111, 1'b0);
        tick(4'b1111, 1'b1);
        total++;
        if (bus4.grant !== 4'b0000) begin bad++; $display("FAIL mid_reset_drop: got %b want 0000", bus4.grant); end
        tick(4'b1111, 1'b0);
        total++;
        if (bus4.grant !== 4'b0001) begin bad++; $display("FAIL mid_reset_restart: got %b want 0001", bus4.grant); end
    endtask

    task automatic test_random;
        logic [3:0] r;
        r = 4'b0000;
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 1) == 0) r = 4'($urandom_range(0, 15));
            tick(r, ($urandom_range(0, 59) == 0));
        end
    endtask

    initial begin
        bus4.req = 4'b0000;
        bus0.req = 4'b0000;
        test_reset();
        test_single_hold();
        test_rotation();
        test_no_limit();
        test_drop_idle();
        test_mid_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
